displayscan: RTL and testbench
==============================

# displayscan

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. It holds a packed BCD value and walks one digit at a time at a programmable rate. For each digit it drives one BCD nibble into the downstream BCD-to-seven-segment decoder and asserts the matching active-low anode. It sits directly upstream of the decoder: `bcd` feeds the decoder input, and `an` goes to the board anode pins.

## Interface
- `CLK_DIV`, default 50000: clock cycles each digit stays lit. Legal range is 2 to 2^20.
- `NDIG`, default 4: number of digits. The block is verified at 4.
- `clk`, input, 1 bit: single clock. All state changes on the rising edge.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `value`, input, 4*NDIG bits: packed BCD. Digit k is `value[4k+3:4k]`, with digit 0 the least significant.
- `load`, input, 1 bit: captures `value` into the shadow register.
- `en`, input, 1 bit: scan enable. When 0, the display is dark and scanning is frozen.
- `blank_lz`, input, 1 bit: leading-zero blanking enable.
- `bcd`, output, 4 bits: registered nibble to the decoder. The code 4'hF means blank.
- `an`, output, NDIG bits: registered active-low anode select. At most one bit is 0 at any time.
- `frame_tick`, output, 1 bit: one-cycle pulse, registered, on the cycle digit 0 becomes lit.

## Operation
- **Shadow register.**
  - Loads `value` on any clock with `load`=1, regardless of `en`.
  - Resets to 0.
  - Display outputs read only the shadow register, never `value` directly.
- **Prescaler.**
  - Counts 0 to CLK_DIV-1 while `en`=1, then wraps to 0.
  - `tick` is asserted when the count equals CLK_DIV-1.
  - Holds its count while `en`=0.
- **Digit pointer `d`.**
  - Reset value is NDIG-1, so the first tick selects digit 0.
  - On each tick, `d` advances to (d+1) mod NDIG. It wraps from NDIG-1 to 0.
- **Output update.** On a tick, the outputs are registered for the new `d`:
  - `an` is all ones except bit `d`, which is 0.
  - `bcd` is the shadow nibble `d`, or 4'hF if that digit is blanked.
- **Leading-zero blanking.**
  - With `blank_lz`=1, digit k (k≥1) is blanked when shadow digits NDIG-1 down to k are all zero.
  - Digit 0 is never blanked, so a value of 0 shows as a single "0".
- **Invalid nibbles.** Nibbles 10 to 15 are passed through unchanged. The decoder renders them dark.
- **Disable.**
  - `en`=0 forces `an` to all ones and `bcd` to 4'hF on the next clock.
  - The prescaler count and `d` are held.
  - On re-enable, the outputs stay dark until the next tick, which shows digit (d+1) mod NDIG.
- **`frame_tick`.** Goes high for exactly one cycle, coincident with the `an`/`bcd` update that selects digit 0.

## Timing
- **Reset values.** Prescaler 0, `d` = NDIG-1, shadow 0, `an` all ones, `bcd` 4'hF, `frame_tick` 0.
  - Reset is asynchronous assert and synchronous-edge release.
  - Reset mid-scan immediately darkens the display.
- **First lit digit.** With `en`=1 from reset release, the first tick is at count CLK_DIV-1. Digit 0 is lit on the CLK_DIV-th rising edge after release.
- **Dwell.** Each digit stays lit for exactly CLK_DIV cycles. A full frame is NDIG*CLK_DIV cycles.
- **Load latency.**
  - A loaded value becomes visible at the next tick after the load edge.
  - If `load` and `tick` fall in the same cycle, the new digit shows the old shadow value. The loaded value appears from the following tick onward.
- **Blanking changes.** `blank_lz` changes take effect at the next tick.
- **No overlap.** `an` and `bcd` change on the same edge, so no cycle ever shows a mismatched nibble and anode.

## Structure
- **Shared package `segpkg`** holds:
  - `BLANK_CODE` = 4'hF
  - the NDIG default
  - `AN_OFF` (all ones)
  - the function `lzmask(shadow)` that returns the per-digit blank mask
- **Sub-module `tickgen`** is the parameterised prescaler:
  - inputs `clk`, `rst_n`, `en`
  - output `tick`
- The pointer, shadow register and output registers live in `displayscan`.

## Test plan
All scenarios use CLK_DIV=4 and NDIG=4.
- **Reset and first frame.** Release reset with `en`=1, then load 16'h1234.
  - Cycles 1 to 3: `an`=1111, `bcd`=F.
  - Edge 4: `an`=1110, `bcd`=4, `frame_tick`=1 for one cycle.
  - Edges 8, 12 and 16: `an` = 1101, 1011, 0111 with `bcd` = 3, 2, 1.
  - Edge 20: `an`=1110 again.
- **Leading-zero blanking.** `blank_lz`=1 with shadow 16'h0040.
  - Scan yields `bcd` = 0, 4, F, F.
  - With shadow 16'h0000, scan yields `bcd` = 0, F, F, F.
- **Load/tick collision.** Shadow holds 16'h1111. Load 16'h9999 on the cycle with tick=1.
  - The newly lit digit shows 1.
  - The next digit shows 9.
- **Disable and resume.** Drop `en` while digit 2 is lit.
  - Next edge: `an`=1111, `bcd`=F.
  - Hold 10 cycles, then re-enable. `an` stays 1111 until the prescaler finishes its held count, then `an`=0111.
- **Asynchronous reset mid-scan.** Assert `rst_n`=0 between edges while digit 1 is lit.
  - `an`=1111 and `bcd`=F immediately, without waiting for a clock edge.
  - Shadow reads 0 after release.
- **Invalid nibble.** Load 16'h00A0 with `blank_lz`=0.
  - Digit 1 drives `bcd`=A.
  - The anode sequence is unaffected.

Source files
------------

// File: rtl/displayscan_pkg.sv
// Shared constants and the leading-zero blank mask for the seven-segment scanner.
// Blanking logic is sized for up to NDIG_DEFAULT digits.
package segpkg;

   localparam int                      NDIG_DEFAULT = 4;
   localparam logic [3:0]              BLANK_CODE   = 4'hF;
   localparam logic [NDIG_DEFAULT-1:0] AN_OFF       = '1;

   // Bit k is set when digits NDIG_DEFAULT-1 down to k are all zero.
   // Digit 0 is never blanked.
   function automatic logic [NDIG_DEFAULT-1:0] lzmask(input logic [4*NDIG_DEFAULT-1:0] shadow);
      logic all_zero;
      lzmask   = '0;
      all_zero = 1'b1;
      for (int k = NDIG_DEFAULT - 1; k >= 1; k--) begin
         all_zero  = all_zero && (shadow[4*k +: 4] == 4'h0);
         lzmask[k] = all_zero;
      end
   endfunction

endpackage

// File: rtl/displayscan_tickgen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled and pulses tick on the last count.
// The count is frozen while en is low.
module tickgen #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/displayscan.sv
// Four-digit common-anode display scanner: shadow BCD register, digit pointer
// and registered anode/nibble outputs feeding a BCD-to-seven-segment decoder.
module displayscan
   import segpkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int NDIG    = NDIG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4*NDIG-1:0] value,
   input  logic              load,
   input  logic              en,
   input  logic              blank_lz,
   output logic [3:0]        bcd,
   output logic [NDIG-1:0]   an,
   output logic              frame_tick
);

   localparam int              PW      = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [PW-1:0]   D_LAST  = PW'(NDIG - 1);
   localparam logic [NDIG-1:0] AN_DARK = '1;

   logic [4*NDIG-1:0]         shadow;
   logic [4*NDIG_DEFAULT-1:0] shadow_ext;
   logic [NDIG_DEFAULT-1:0]   blank_mask;
   logic [PW-1:0]             d;
   logic [PW-1:0]             d_next;
   logic                      tick;

   tickgen #(
      .CLK_DIV (CLK_DIV)
   ) u_tickgen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   // NOTE: assign a default first in every always_comb so no path leaves a
   // variable unassigned and infers a latch.
   always_comb begin
      shadow_ext              = '0;
      shadow_ext[4*NDIG-1:0]  = shadow;
   end

   assign blank_mask = blank_lz ? lzmask(shadow_ext) : '0;
   assign d_next     = (d == D_LAST) ? '0 : d + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= value;
      end
   end

   // Pointer rests on the last digit so the first tick lands on digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d <= D_LAST;
      end else if (tick) begin
         d <= d_next;
      end
   end

   // Anode and nibble share one register stage so they always change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_DARK;
         bcd        <= BLANK_CODE;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         if (!en) begin
            an  <= AN_DARK;
            bcd <= BLANK_CODE;
         end else if (tick) begin
            an         <= ~(NDIG'(1) << d_next);
            bcd        <= blank_mask[d_next] ? BLANK_CODE : shadow[4*d_next +: 4];
            frame_tick <= (d_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_displayscan.sv
// Scoreboard bench for displayscan at CLK_DIV=4, NDIG=4: stimulus queues each
// expected display update, a negedge monitor pops and compares on every change.
module tb_displayscan;

   localparam int CLK_DIV = 4;
   localparam int NDIG    = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [15:0]     value;
   logic            load;
   logic            en;
   logic            blank_lz;
   logic [3:0]      bcd;
   logic [NDIG-1:0] an;
   logic            frame_tick;

   typedef struct {
      string      name;
      logic [3:0] an;
      logic [3:0] bcd;
      logic       ft;
      int         dwell;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;
   int   pe     = -3;

   displayscan #(
      .CLK_DIV (CLK_DIV),
      .NDIG    (NDIG)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .en         (en),
      .blank_lz   (blank_lz),
      .bcd        (bcd),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic ft, input int dwell);
      exp_t e;
      e.name  = name;
      e.an    = a;
      e.bcd   = b;
      e.ft    = ft;
      e.dwell = dwell;
      exp_q.push_back(e);
   endtask

   // Advance to 1 time unit after rising edge k (edge 0 is the reset-release edge).
   task automatic go(input int k);
      while (pe < k) begin
         @(posedge clk);
         pe++;
      end
      #1;
   endtask

   // Monitor: an update is any change of {an,bcd}; dwell counts negedges since
   // the previous update (or since the last negedge that saw reset low).
   logic [7:0] prev  = 8'hFF;
   logic [7:0] cur;
   int         since = 0;
   exp_t       item;

   always @(negedge clk) begin
      since++;
      cur = {an, bcd};
      if (cur != prev) begin
         check("update expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            check({item.name, " an"},  int'(an),         int'(item.an));
            check({item.name, " bcd"}, int'(bcd),        int'(item.bcd));
            check({item.name, " ft"},  int'(frame_tick), int'(item.ft));
            if (item.dwell >= 0) check({item.name, " dwell"}, since, item.dwell);
         end
         since = 0;
      end else begin
         check("frame_tick idle", int'(frame_tick), 0);
      end
      check("an one-hot-low", int'($countones(~an) <= 1), 1);
      if (!rst_n) since = 0;
      prev = cur;
   end

   initial begin
      rst_n    = 1'b0;
      value    = 16'h0000;
      load     = 1'b0;
      en       = 1'b0;
      blank_lz = 1'b0;

      // Reset and first frame
      go(0);
      check("reset an",  int'(an),         4'hF);
      check("reset bcd", int'(bcd),        4'hF);
      check("reset ft",  int'(frame_tick), 0);
      rst_n = 1'b1;
      en    = 1'b1;
      load  = 1'b1;
      value = 16'h1234;
      push("first d0", 4'b1110, 4'h4, 1'b1, CLK_DIV + 1);
      push("first d1", 4'b1101, 4'h3, 1'b0, CLK_DIV);
      push("first d2", 4'b1011, 4'h2, 1'b0, CLK_DIV);
      push("first d3", 4'b0111, 4'h1, 1'b0, CLK_DIV);
      push("frame2 d0", 4'b1110, 4'h4, 1'b1, CLK_DIV);
      go(1);
      load = 1'b0;
      check("dark c1", int'(an), 4'hF);
      go(2);
      check("dark c2", int'(an), 4'hF);
      go(3);
      check("dark c3 an",  int'(an),  4'hF);
      check("dark c3 bcd", int'(bcd), 4'hF);

      // Leading-zero blanking, 0040 then 0000
      go(20);
      load     = 1'b1;
      value    = 16'h0040;
      blank_lz = 1'b1;
      push("lz40 d1", 4'b1101, 4'h4, 1'b0, CLK_DIV);
      push("lz40 d2", 4'b1011, 4'hF, 1'b0, CLK_DIV);
      push("lz40 d3", 4'b0111, 4'hF, 1'b0, CLK_DIV);
      push("lz40 d0", 4'b1110, 4'h0, 1'b1, CLK_DIV);
      go(21);
      load = 1'b0;
      go(36);
      load  = 1'b1;
      value = 16'h0000;
      push("lz00 d1", 4'b1101, 4'hF, 1'b0, CLK_DIV);
      push("lz00 d2", 4'b1011, 4'hF, 1'b0, CLK_DIV);
      push("lz00 d3", 4'b0111, 4'hF, 1'b0, CLK_DIV);
      push("lz00 d0", 4'b1110, 4'h0, 1'b1, CLK_DIV);
      go(37);
      load = 1'b0;

      // Load/tick collision
      go(52);
      load     = 1'b1;
      value    = 16'h1111;
      blank_lz = 1'b0;
      push("pre d1", 4'b1101, 4'h1, 1'b0, CLK_DIV);
      go(53);
      load = 1'b0;
      go(59);
      load  = 1'b1;
      value = 16'h9999;
      push("collide d2", 4'b1011, 4'h1, 1'b0, CLK_DIV);
      push("after d3",   4'b0111, 4'h9, 1'b0, CLK_DIV);
      push("after d0",   4'b1110, 4'h9, 1'b1, CLK_DIV);
      push("after d1",   4'b1101, 4'h9, 1'b0, CLK_DIV);
      push("after d2",   4'b1011, 4'h9, 1'b0, CLK_DIV);
      go(60);
      load = 1'b0;

      // Disable while digit 2 lit, hold 10 cycles, resume
      go(77);
      en = 1'b0;
      push("disable", 4'b1111, 4'hF, 1'b0, 2);
      go(87);
      en = 1'b1;
      push("resume d3", 4'b0111, 4'h9, 1'b0, 12);
      push("resume d0", 4'b1110, 4'h9, 1'b1, CLK_DIV);
      push("resume d1", 4'b1101, 4'h9, 1'b0, CLK_DIV);

      // Asynchronous reset while digit 1 lit
      go(99);
      #1;
      rst_n = 1'b0;
      push("async rst", 4'b1111, 4'hF, 1'b0, 1);
      #1;
      check("async rst an",  int'(an),         4'hF);
      check("async rst bcd", int'(bcd),        4'hF);
      check("async rst ft",  int'(frame_tick), 0);
      go(102);
      rst_n = 1'b1;
      push("post-rst d0", 4'b1110, 4'h0, 1'b1, CLK_DIV + 1);
      push("post-rst d1", 4'b1101, 4'h0, 1'b0, CLK_DIV);

      // Invalid nibble pass-through
      go(110);
      load  = 1'b1;
      value = 16'h00A0;
      push("inv d2", 4'b1011, 4'h0, 1'b0, CLK_DIV);
      push("inv d3", 4'b0111, 4'h0, 1'b0, CLK_DIV);
      push("inv d0", 4'b1110, 4'h0, 1'b1, CLK_DIV);
      push("inv d1", 4'b1101, 4'hA, 1'b0, CLK_DIV);
      push("inv d2b", 4'b1011, 4'h0, 1'b0, CLK_DIV);
      go(111);
      load = 1'b0;

      go(131);
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
